// File: rtl/seven_segment_digit_scanner_if.sv
// seven_segment_digit_scanner_if: value load handshake between producer and scanner
interface seven_segment_digit_scanner_if;
  logic [15:0] value_in;
  logic value_valid;
  logic value_ready;
  modport master(output value_in, value_valid, input value_ready);
  modport slave(input value_in, value_valid, output value_ready);
endinterface

// File: rtl/seven_segment_digit_scanner.sv
// seven_segment_digit_scanner: 4-digit multiplexed scan with dead time, zero blanking and tear-free double buffering
module seven_segment_digit_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  seven_segment_digit_scanner_if.slave vif,
  input  logic suppress_zeros,
  output logic [3:0] bin,
  output logic [3:0] digit_en,
  output logic blank,
  output logic frame_tick
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);
  logic [PW-1:0] p, p_n;
  logic [1:0] d, d_n;
  logic [15:0] disp, disp_n, shadow;
  logic shadow_full, wrap, boundary, accept, blank_n;
  logic [3:0] sup, bin_n, en_n;
  assign vif.value_ready = !shadow_full && !rst;
  // next scan position and the registered outputs that belong to it
  always_comb begin
    wrap = p == P_LAST;
    boundary = wrap && d == 2'd3;
    accept = vif.value_valid && vif.value_ready;
    p_n = wrap ? '0 : p + 1'b1;
    d_n = wrap ? d + 2'd1 : d;
    disp_n = boundary && shadow_full ? shadow : disp;
    sup = suppress_zeros ? {disp_n[15:12] == 4'd0, disp_n[15:8] == 8'd0, disp_n[15:4] == 12'd0, 1'b0} : 4'b0;
    bin_n = disp_n[{d_n, 2'b00} +: 4];
    blank_n = p_n < P_DEAD;
    en_n = blank_n || sup[d_n] ? 4'b0 : 4'b1 << d_n;
  end
  // scan state, display/shadow swap at frame boundary, output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      d <= '0;
      disp <= '0;
      shadow_full <= 1'b0;
      bin <= '0;
      digit_en <= '0;
      blank <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      p <= p_n;
      d <= d_n;
      disp <= disp_n;
      bin <= bin_n;
      digit_en <= en_n;
      blank <= blank_n;
      frame_tick <= boundary;
      if (boundary && shadow_full) shadow_full <= 1'b0;
      else if (accept) shadow_full <= 1'b1;
    end
  end
  // shadow data; only captured on an accepted offer
  always_ff @(posedge clk) begin
    if (accept) shadow <= vif.value_in;
  end
endmodule

// File: tb/tb_seven_segment_digit_scanner.sv
// tb_seven_segment_digit_scanner: randomized scan checks against a cycle-count based display model
module tb_seven_segment_digit_scanner;
  logic clk = 1'b0, rst = 1'b1, sz = 1'b0;
  logic [3:0] bin, digit_en;
  logic blank, frame_tick;
  int vectors = 0, errors = 0;
  int n = 0;
  logic [15:0] m_disp = '0, m_shadow = '0;
  bit m_full = 1'b0, m_sz = 1'b0;

  always #5 clk = ~clk;

  seven_segment_digit_scanner_if vif();

  seven_segment_digit_scanner #(.REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .vif(vif), .suppress_zeros(sz),
    .bin(bin), .digit_en(digit_en), .blank(blank), .frame_tick(frame_tick)
  );

  function automatic logic [10:0] expv();
    int p, dd;
    logic [15:0] upper;
    logic [3:0] en;
    bit bl, tk;
    p = n % 8;
    dd = (n / 8) % 4;
    upper = m_disp >> (4 * dd);
    bl = p < 2;
    en = (bl || (m_sz && dd > 0 && upper == 16'd0)) ? 4'b0 : 4'(1 << dd);
    tk = n > 0 && n % 32 == 0;
    return {upper[3:0], en, bl, tk, !m_full && !rst};
  endfunction

  function automatic logic [10:0] obsv();
    return {bin, digit_en, blank, frame_tick, vif.value_ready};
  endfunction

  task automatic step();
    bit acc;
    bit s;
    logic [15:0] v;
    acc = vif.value_valid && !m_full && !rst;
    s = sz;
    v = vif.value_in;
    @(posedge clk);
    if (rst) begin
      n = 0;
      m_disp = '0;
      m_full = 1'b0;
    end else begin
      n++;
      if (n % 32 == 0 && m_full) begin
        m_disp = m_shadow;
        m_full = 1'b0;
      end else if (acc) begin
        m_shadow = v;
        m_full = 1'b1;
      end
    end
    m_sz = s;
    #1;
  endtask

  task automatic test_reset();
    int cnt [4];
    rst = 1'b1;
    repeat (3) begin
      step();
      vectors++;
      if (obsv() !== 11'b0000_0000_1_0_0) begin
        errors++;
        $display("FAIL reset_values got %b want 00000000100", obsv());
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (vif.value_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release got %b want 1", vif.value_ready);
    end
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    repeat (32) begin
      step();
      vectors++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL first_frame n=%0d got %b want %b", n, obsv(), expv());
      end
      for (int k = 0; k < 4; k++) if (digit_en == 4'(1 << k)) cnt[k]++;
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (cnt[k] != 6) begin
        errors++;
        $display("FAIL first_frame_on_cycles digit %0d got %0d want 6", k, cnt[k]);
      end
    end
  endtask

  task automatic test_load(input logic [15:0] val, input logic s, input string name);
    sz = s;
    vif.value_in = val;
    vif.value_valid = 1'b1;
    step();
    vectors++;
    if (vif.value_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s accept_ready got %b want 0", name, vif.value_ready);
    end
    vif.value_valid = 1'b0;
    vif.value_in = 16'($urandom);
    repeat (70) begin
      step();
      vectors++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL %s n=%0d got %b want %b", name, n, obsv(), expv());
      end
    end
  endtask

  task automatic test_suppress();
    test_load(16'h0070, 1'b1, "suppress_0070");
    test_load(16'h0070, 1'b0, "nosuppress_0070");
    test_load(16'h0000, 1'b1, "suppress_0000");
    test_load(16'h0305, 1'b1, "suppress_0305");
  endtask

  task automatic test_back_to_back();
    sz = 1'b0;
    vif.value_in = 16'hAAAA;
    vif.value_valid = 1'b1;
    step();
    vif.value_in = 16'hBBBB;
    repeat (110) begin
      vectors++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL back_to_back n=%0d got %b want %b", n, obsv(), expv());
      end
      if (m_full && m_shadow == 16'hBBBB) vif.value_valid = 1'b0;
      step();
    end
    vectors++;
    if (m_disp !== 16'hBBBB || bin !== 4'hB) begin
      errors++;
      $display("FAIL back_to_back_final got bin %h want b", bin);
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    sz = 1'b0;
    vif.value_in = 16'h5A5A;
    vif.value_valid = 1'b1;
    step();
    vif.value_valid = 1'b0;
    repeat (64) step();
    vif.value_in = 16'hC3C3;
    vif.value_valid = 1'b1;
    step();
    vif.value_valid = 1'b0;
    while ((n / 8) % 4 != 2 && guard < 64) begin
      step();
      guard++;
    end
    vectors++;
    if (guard >= 64 || !m_full) begin
      errors++;
      $display("FAIL mid_reset_setup got guard %0d full %0d want digit 2 with shadow full", guard, m_full);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (obsv() !== 11'b0000_0000_1_0_0) begin
      errors++;
      $display("FAIL mid_reset_values got %b want 00000000100", obsv());
    end
    repeat (70) begin
      step();
      vectors++;
      if (obsv() !== expv() || (digit_en != 4'b0 && bin != 4'h0)) begin
        errors++;
        $display("FAIL mid_reset_scan n=%0d got %b want %b", n, obsv(), expv());
      end
    end
  endtask

  task automatic test_random();
    repeat (600) begin
      vif.value_valid = 1'($urandom_range(0, 3) == 0);
      vif.value_in = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) sz = ~sz;
      step();
      vectors++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL random n=%0d got %b want %b", n, obsv(), expv());
      end
    end
    vif.value_valid = 1'b0;
  endtask

  task automatic test_free_run();
    int prev = -1, c = 0, ticks = 0;
    repeat (160) begin
      step();
      c++;
      vectors++;
      if ($countones(digit_en) > 1 || obsv() !== expv()) begin
        errors++;
        $display("FAIL free_run n=%0d got %b want %b", n, obsv(), expv());
      end
      if (frame_tick) begin
        ticks++;
        if (prev >= 0) begin
          vectors++;
          if (c - prev != 32) begin
            errors++;
            $display("FAIL tick_spacing got %0d want 32", c - prev);
          end
        end
        prev = c;
      end
    end
    vectors++;
    if (ticks != 5) begin
      errors++;
      $display("FAIL tick_count got %0d want 5", ticks);
    end
  endtask

  initial begin
    vif.value_in = '0;
    vif.value_valid = 1'b0;
    test_reset();
    test_load(16'h1234, 1'b0, "load_1234");
    test_suppress();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_free_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/seven_segment_digit_scanner.md
Name: seven_segment_digit_scanner

Overview:
Time-multiplexed scan driver for a 4-digit common-anode/cathode seven-segment display. It holds a 16-bit display value and steps through its four nibbles. For each digit slot it presents the nibble on `bin`, which feeds `bin_to_seven_segment` directly downstream, and it drives a one-hot digit enable. It inserts dead time between digits to prevent ghosting, and it double-buffers new values so a frame never tears.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- DEAD_CYCLES, 500: blanked cycles at the start of each slot; legal range 1 ≤ DEAD_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- value_in  in  16  value to display; nibble k goes to digit k, and digit 0 is the least significant.
- value_valid  in  1  value_in is offered.
- value_ready  out  1  shadow register empty; a value is accepted when valid && ready.
- suppress_zeros  in  1  enables leading-zero blanking.
- bin  out  4  current digit nibble, feeding bin_to_seven_segment.bin.
- digit_en  out  4  one-hot digit enable, active-high.
- blank  out  1  high during dead time.
- frame_tick  out  1  one-cycle pulse at the start of each new frame.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- State: prescaler p (0..REFRESH_DIV-1), digit index d (0..3), display_reg[15:0], shadow_reg[15:0], shadow_full.
- Output timing: all outputs except value_ready are flops. They are updated on the same edge as p and d, so they always correspond to the current p and d.
- Reset values: p=0, d=0, display_reg=0, shadow_full=0, bin=0, digit_en=0000, blank=1, frame_tick=0. value_ready=0 while rst=1.
- Reset priority: rst overrides every other event, including a mid-frame reset or an in-flight accept. The shadow contents are discarded.
- Prescaler: p increments each cycle. At REFRESH_DIV-1 it wraps to 0 and d advances (3 wraps to 0).
- One frame is 4*REFRESH_DIV cycles.
- Blanking: blank = (p < DEAD_CYCLES).
- Digit enable: digit_en = 0000 when blank=1. Otherwise digit_en = onehot(d), or 0000 if digit d is suppressed.
- Digit data: bin = display_reg[4d+3:4d] for the whole slot, including dead time, so the decoder settles before enable.
- Leading-zero suppression: when suppress_zeros=1, digit k (k ≥ 1) is suppressed iff display_reg[15:4k]==0. Digit 0 is never suppressed.
  - suppress_zeros is sampled every cycle, with no latching.
- Handshake:
  - value_ready = !shadow_full (combinational, forced 0 during rst).
  - On valid && ready: shadow_reg ← value_in and shadow_full ← 1.
  - value_in may change freely when not accepted.
- Frame boundary (the edge where p wraps and d goes 3→0):
  - frame_tick=1 for exactly that cycle. It is not asserted on the first frame after reset.
  - If shadow_full: display_reg ← shadow_reg and shadow_full ← 0, so value_ready rises in the frame_tick cycle.
  - The new value is displayed from digit 0 of the new frame.
- Simultaneous accept and boundary: an accept can only occur with shadow empty. A value accepted on the boundary edge lands in shadow and is displayed from the following boundary; there is no bypass path.
- No combinational path exists from value_valid to value_ready.

Test Plan:
Bench settings: REFRESH_DIV=8, DEAD_CYCLES=2; frame = 32 cycles.

1. Reset check: hold rst for 3 cycles, then release.
   - During rst: digit_en=0000, blank=1, bin=0, frame_tick=0, value_ready=0.
   - The cycle after release: value_ready=1.
   - First frame displays 0000 on all digits; each digit_en is high for 6 cycles after 2 blank cycles.
2. Load 0x1234 with suppress_zeros=0.
   - Accepted in 1 cycle; value_ready goes 0.
   - At the next frame_tick, value_ready returns to 1.
   - The scan then shows digit_en 0001/bin 4, 0010/bin 3, 0100/bin 2, 1000/bin 1, with 6 enabled cycles each.
3. Leading-zero suppression:
   - 0x0070, suppress_zeros=1: digits 0 and 1 show bin 0 and 7; in slots 2 and 3, digit_en=0000 with blank=0.
   - 0x0070, suppress_zeros=0: all four digits are enabled.
   - 0x0000, suppress_zeros=1: only digit 0 is enabled, with bin=0.
4. Back-pressure and no tearing:
   - Offer 0xAAAA, then hold 0xBBBB valid. 0xBBBB is not accepted until the frame_tick that loads 0xAAAA.
   - The 0xAAAA frame shows only A on all digits; 0xBBBB appears exactly one frame later.
5. Mid-frame reset: assert rst for 1 cycle during digit 2 with shadow_full=1.
   - Next cycle shows reset values; the display scans 0000, and the shadow value is never displayed.
6. Free-run for 5 frames: frame_tick pulses are exactly 32 cycles apart and 1 cycle wide; digit_en is never multi-hot.
